// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store bus master: access sizes, response
// codes and the controller state.
package lsu_pkg;

    // Access size codes carried on req_size
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Completion codes reported on rsp_code
    localparam logic [1:0] RSP_OK       = 2'd0;
    localparam logic [1:0] RSP_MISALIGN = 2'd1;
    localparam logic [1:0] RSP_BUSERR   = 2'd2;
    localparam logic [1:0] RSP_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store bus master. Purely combinational:
// store side builds the lane enables, shifted store data and misalign flag
// from the live request; load side extracts and extends the returned word
// using the offset/size captured when the access was accepted.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int SEL_W = DATA_W / 8,
    localparam int OFF_W = $clog2(SEL_W)
) (
    input  logic [OFF_W-1:0]  st_off,
    input  logic [1:0]        st_size,
    input  logic [DATA_W-1:0] st_wdata,
    output logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] st_data,
    output logic              misalign,
    input  logic [OFF_W-1:0]  ld_off,
    input  logic [1:0]        ld_size,
    input  logic              ld_signed,
    input  logic [DATA_W-1:0] ld_raw,
    output logic [DATA_W-1:0] ld_data
);

    int                lane_lo;
    int                lane_hi;
    logic [DATA_W-1:0] ld_shift;
    int                ld_bits;
    logic              ld_fill;

    // Lane window [lane_lo, lane_hi) covered by the store/load access
    always_comb begin
        lane_lo = int'(st_off);
        lane_hi = lane_lo + (1 << st_size);
    end

    genvar gi;
    generate
        for (gi = 0; gi < SEL_W; gi++) begin : g_sel
            assign sel[gi] = (gi >= lane_lo) && (gi < lane_hi);
        end
    endgenerate

    assign st_data = st_wdata << {st_off, 3'b000};

    // Natural alignment check; a dword is never legal on a 32-bit bus
    always_comb begin
        misalign = 1'b0;
        case (st_size)
            SZ_B:    misalign = 1'b0;
            SZ_H:    misalign = st_off[0];
            SZ_W:    misalign = |st_off[1:0];
            default: misalign = (DATA_W == 32) ? 1'b1 : (|st_off);
        endcase
    end

    // Right-justify the selected lanes and find the sign bit of the access
    always_comb begin
        ld_shift = ld_raw >> {ld_off, 3'b000};
        ld_bits  = 8 << ld_size;
        if (ld_bits > DATA_W) begin
            ld_bits = DATA_W;
        end
        ld_fill = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == ld_bits - 1) begin
                ld_fill = ld_signed & ld_shift[i];
            end
        end
    end

    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_ext
            assign ld_data[gi] = (gi < ld_bits) ? ld_shift[gi] : ld_fill;
        end
    endgenerate

endmodule

// File: rtl/lsu_bus_master.sv
// Registered load/store bus master. Accepts one CPU access at a time,
// runs a single strobed bus cycle (or rejects it as misaligned), and
// reports completion with a one-cycle rsp_valid pulse.
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int SEL_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        rsp_code,
    output logic              STB,
    output logic              WE,
    output logic [ADDR_W-1:0] Addr,
    output logic [SEL_W-1:0]  SEL,
    output logic [DATA_W-1:0] Data_O,
    input  logic [DATA_W-1:0] Data_I,
    input  logic              ACK,
    input  logic              ERR
);

    localparam int OFF_W   = $clog2(SEL_W);
    localparam int TMR_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit WDOG_EN = (TIMEOUT > 0);

    state_t            state_reg, state_next;
    logic              stb_reg, stb_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [SEL_W-1:0]  sel_reg, sel_next;
    logic [DATA_W-1:0] data_o_reg, data_o_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic [1:0]        code_reg, code_next;
    logic [TMR_W-1:0]  timer_reg, timer_next;
    logic [OFF_W-1:0]  ld_off_reg, ld_off_next;
    logic [1:0]        ld_size_reg, ld_size_next;
    logic              ld_signed_reg, ld_signed_next;

    logic [SEL_W-1:0]  lane_sel;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_rdata;
    logic              lane_misalign;
    logic              timeout_hit;

    lsu_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .st_off    (req_addr[OFF_W-1:0]),
        .st_size   (req_size),
        .st_wdata  (req_wdata),
        .sel       (lane_sel),
        .st_data   (lane_wdata),
        .misalign  (lane_misalign),
        .ld_off    (ld_off_reg),
        .ld_size   (ld_size_reg),
        .ld_signed (ld_signed_reg),
        .ld_raw    (Data_I),
        .ld_data   (lane_rdata)
    );

    assign timeout_hit = WDOG_EN && (timer_reg == TMR_W'(TIMEOUT));

    // Controller state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Bus outputs, response holding registers, watchdog and captured load shape
    always_ff @(posedge clk) begin
        if (reset) begin
            stb_reg       <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            sel_reg       <= '0;
            data_o_reg    <= '0;
            rdata_reg     <= '0;
            code_reg      <= RSP_OK;
            timer_reg     <= '0;
            ld_off_reg    <= '0;
            ld_size_reg   <= SZ_B;
            ld_signed_reg <= 1'b0;
        end else begin
            stb_reg       <= stb_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            sel_reg       <= sel_next;
            data_o_reg    <= data_o_next;
            rdata_reg     <= rdata_next;
            code_reg      <= code_next;
            timer_reg     <= timer_next;
            ld_off_reg    <= ld_off_next;
            ld_size_reg   <= ld_size_next;
            ld_signed_reg <= ld_signed_next;
        end
    end

    // Next-state and datapath decisions; ERR beats ACK beats the watchdog
    always_comb begin
        state_next     = state_reg;
        stb_next       = stb_reg;
        we_next        = we_reg;
        addr_next      = addr_reg;
        sel_next       = sel_reg;
        data_o_next    = data_o_reg;
        rdata_next     = rdata_reg;
        code_next      = code_reg;
        timer_next     = timer_reg;
        ld_off_next    = ld_off_reg;
        ld_size_next   = ld_size_reg;
        ld_signed_next = ld_signed_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    rdata_next     = '0;
                    ld_off_next    = req_addr[OFF_W-1:0];
                    ld_size_next   = req_size;
                    ld_signed_next = req_signed;
                    if (lane_misalign) begin
                        code_next  = RSP_MISALIGN;
                        state_next = RESP;
                    end else begin
                        code_next   = RSP_OK;
                        stb_next    = 1'b1;
                        we_next     = req_we;
                        addr_next   = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        sel_next    = lane_sel;
                        data_o_next = lane_wdata;
                        timer_next  = '0;
                        state_next  = BUS;
                    end
                end
            end
            BUS: begin
                if (ERR) begin
                    code_next  = RSP_BUSERR;
                    rdata_next = '0;
                    stb_next   = 1'b0;
                    state_next = RESP;
                end else if (ACK) begin
                    code_next  = RSP_OK;
                    rdata_next = we_reg ? '0 : lane_rdata;
                    stb_next   = 1'b0;
                    state_next = RESP;
                end else if (timeout_hit) begin
                    code_next  = RSP_TIMEOUT;
                    rdata_next = '0;
                    stb_next   = 1'b0;
                    state_next = RESP;
                end else if (timer_reg != '1) begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy      = (state_reg != IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_err   = rsp_valid && (code_reg != RSP_OK);
    assign rsp_rdata = rdata_reg;
    assign rsp_code  = code_reg;
    assign STB       = stb_reg;
    assign WE        = we_reg;
    assign Addr      = addr_reg;
    assign SEL       = sel_reg;
    assign Data_O    = data_o_reg;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: a 32-bit and a 64-bit instance share the same
// request and bus stimulus; a transaction-level model predicts each cycle.
module tb_lsu_bus_master;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        rv32, rv64;
    logic        req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, Data_I;
    logic        ACK, ERR;

    logic        busy32, rsp_valid32, rsp_err32, STB32, WE32;
    logic [1:0]  rsp_code32;
    logic [31:0] rsp_rdata32, Addr32, Data_O32;
    logic [3:0]  SEL32;
    logic        busy64, rsp_valid64, rsp_err64, STB64, WE64;
    logic [1:0]  rsp_code64;
    logic [63:0] rsp_rdata64, Data_O64;
    logic [31:0] Addr64;
    logic [7:0]  SEL64;

    lsu_bus_master #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TMO)) dut32 (
        .clk(clk), .reset(reset), .req_valid(rv32), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .busy(busy32), .rsp_valid(rsp_valid32),
        .rsp_rdata(rsp_rdata32), .rsp_err(rsp_err32), .rsp_code(rsp_code32),
        .STB(STB32), .WE(WE32), .Addr(Addr32), .SEL(SEL32), .Data_O(Data_O32),
        .Data_I(Data_I[31:0]), .ACK(ACK), .ERR(ERR));

    lsu_bus_master #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TMO)) dut64 (
        .clk(clk), .reset(reset), .req_valid(rv64), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy64), .rsp_valid(rsp_valid64),
        .rsp_rdata(rsp_rdata64), .rsp_err(rsp_err64), .rsp_code(rsp_code64),
        .STB(STB64), .WE(WE64), .Addr(Addr64), .SEL(SEL64), .Data_O(Data_O64),
        .Data_I(Data_I), .ACK(ACK), .ERR(ERR));

    // Index 0 = 32-bit instance, 1 = 64-bit instance
    logic        a_busy[2], a_rv[2], a_err[2], a_stb[2], a_we[2];
    logic [1:0]  a_code[2];
    logic [63:0] a_rdata[2], a_do[2];
    logic [31:0] a_addr[2];
    logic [7:0]  a_sel[2];

    assign a_busy[0] = busy32;      assign a_busy[1] = busy64;
    assign a_rv[0] = rsp_valid32;   assign a_rv[1] = rsp_valid64;
    assign a_err[0] = rsp_err32;    assign a_err[1] = rsp_err64;
    assign a_stb[0] = STB32;        assign a_stb[1] = STB64;
    assign a_we[0] = WE32;          assign a_we[1] = WE64;
    assign a_code[0] = rsp_code32;  assign a_code[1] = rsp_code64;
    assign a_rdata[0] = {32'd0, rsp_rdata32}; assign a_rdata[1] = rsp_rdata64;
    assign a_do[0] = {32'd0, Data_O32};       assign a_do[1] = Data_O64;
    assign a_addr[0] = Addr32;      assign a_addr[1] = Addr64;
    assign a_sel[0] = {4'd0, SEL32}; assign a_sel[1] = SEL64;

    logic        exp_busy[2], exp_rv[2], exp_stb[2], exp_we[2];
    logic [1:0]  exp_code[2];
    logic [63:0] exp_rdata[2], exp_do[2];
    logic [31:0] exp_addr[2];
    logic [7:0]  exp_sel[2];

    logic [1:0]  last_code[2];
    logic [63:0] last_rdata[2], last_do[2];
    logic [31:0] last_addr[2];
    logic [7:0]  last_sel[2];

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int txn_no = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [63:0] wm(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic m_mis(input int w, input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3 && w == 32) || ((addr % (32'd1 << size)) != 0);
    endfunction

    function automatic logic [7:0] m_sel(input int w, input logic [1:0] size, input logic [31:0] addr);
        int nb, off;
        nb  = 1 << size;
        off = int'(addr % (w / 8));
        return 8'(((1 << nb) - 1) << off);
    endfunction

    function automatic logic [63:0] m_dout(input int w, input logic [31:0] addr, input logic [63:0] wd);
        int off;
        off = int'(addr % (w / 8));
        return ((wd & wm(w)) << (8 * off)) & wm(w);
    endfunction

    function automatic logic [63:0] m_load(input int w, input logic [1:0] size, input logic sgn,
                                           input logic [31:0] addr, input logic [63:0] data);
        int off, nbits;
        logic [63:0] d, m;
        off   = int'(addr % (w / 8));
        nbits = 8 << size;
        d = (data & wm(w)) >> (8 * off);
        m = (nbits >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nbits) - 64'd1);
        d = d & m;
        if (sgn && (((d >> (nbits - 1)) & 64'd1) != 0)) d = d | ~m;
        return d & wm(w);
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            string t;
            t = (d == 0) ? "d32" : "d64";
            if (chk_en) begin
                chk({t, "_busy"}, 64'(a_busy[d]), 64'(exp_busy[d]));
                chk({t, "_stb"}, 64'(a_stb[d]), 64'(exp_stb[d]));
                chk({t, "_rsp_valid"}, 64'(a_rv[d]), 64'(exp_rv[d]));
                chk({t, "_rsp_err"}, 64'(a_err[d]), 64'(exp_rv[d] && exp_code[d] != 2'd0));
                if (exp_stb[d]) begin
                    chk({t, "_we"}, 64'(a_we[d]), 64'(exp_we[d]));
                    chk({t, "_addr"}, 64'(a_addr[d]), 64'(exp_addr[d]));
                    chk({t, "_sel"}, 64'(a_sel[d]), 64'(exp_sel[d]));
                    chk({t, "_data_o"}, a_do[d], exp_do[d]);
                end
                if (exp_rv[d]) begin
                    chk({t, "_rsp_code"}, 64'(a_code[d]), 64'(exp_code[d]));
                    chk({t, "_rsp_rdata"}, a_rdata[d], exp_rdata[d]);
                end
            end
            if (a_rv[d]) begin
                last_code[d]  = a_code[d];
                last_rdata[d] = a_rdata[d];
            end
            if (a_stb[d]) begin
                last_sel[d]  = a_sel[d];
                last_do[d]   = a_do[d];
                last_addr[d] = a_addr[d];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_idle_exp();
        for (int d = 0; d < 2; d++) begin
            exp_busy[d] = 1'b0; exp_stb[d] = 1'b0; exp_rv[d] = 1'b0;
            exp_code[d] = 2'd0;
        end
    endtask

    task automatic clear_last();
        for (int d = 0; d < 2; d++) begin
            last_code[d] = 2'bxx; last_rdata[d] = 'x; last_sel[d] = 'x;
            last_do[d] = 'x; last_addr[d] = 'x;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rv32 = 1'b0; rv64 = 1'b0;
            ACK = ($urandom_range(0, 3) == 0);
            ERR = ($urandom_range(0, 3) == 0);
            Data_I = {$urandom, $urandom};
            set_idle_exp();
        end
    endtask

    // One access presented to both instances; w = wait cycles before the slave
    // answers (w > TMO means the watchdog fires first and the answer arrives late)
    task automatic txn(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [63:0] wdata,
                       input logic [63:0] dval, input int w, input logic err,
                       input logic ackerr);
        int rsp_c[2];
        logic mis[2];
        int r, last, ack_c, wdth;
        logic [1:0] code;
        bit any_al;
        r     = 1 + ((w < TMO) ? w : TMO);
        code  = (w <= TMO) ? (err ? 2'd2 : 2'd0) : 2'd3;
        ack_c = 1 + w;
        for (int d = 0; d < 2; d++) begin
            mis[d]   = m_mis(d ? 64 : 32, size, addr);
            rsp_c[d] = mis[d] ? 1 : r + 1;
        end
        any_al = !mis[0] || !mis[1];
        last = (rsp_c[0] > rsp_c[1]) ? rsp_c[0] : rsp_c[1];
        if (ack_c > last) last = ack_c;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk); #1;
            rv32 = (c <= rsp_c[0]);
            rv64 = (c <= rsp_c[1]);
            req_we = we; req_size = size; req_signed = sgn;
            req_addr = addr; req_wdata = wdata;
            Data_I = {$urandom, $urandom};
            ACK = 1'b0; ERR = 1'b0;
            if (c == ack_c) begin
                if (w <= TMO) begin
                    Data_I = dval;
                    ACK = !err || ackerr;
                    ERR = err;
                end else begin
                    ACK = 1'b1;
                end
            end else if (!(any_al && c >= 1 && c <= r)) begin
                ACK = ($urandom_range(0, 3) == 0);
                ERR = ($urandom_range(0, 3) == 0);
            end
            for (int d = 0; d < 2; d++) begin
                wdth = d ? 64 : 32;
                exp_busy[d]  = (c >= 1) && (c <= rsp_c[d]);
                exp_stb[d]   = !mis[d] && (c >= 1) && (c <= r);
                exp_rv[d]    = (c == rsp_c[d]);
                exp_code[d]  = mis[d] ? 2'd1 : code;
                exp_rdata[d] = (!mis[d] && code == 2'd0 && !we) ?
                               m_load(wdth, size, sgn, addr, dval) : 64'd0;
                exp_we[d]    = we;
                exp_addr[d]  = addr & ~32'(wdth / 8 - 1);
                exp_sel[d]   = m_sel(wdth, size, addr);
                exp_do[d]    = m_dout(wdth, addr, wdata);
            end
        end
        txn_no++;
        $display("txn %0d we=%0d size=%0d signed=%0d addr=%h wait=%0d err=%0d code32=%0d code64=%0d",
                 txn_no, we, size, sgn, addr, w, err, exp_code[0], exp_code[1]);
    endtask

    // Reset lands while both instances are waiting in BUS; a late ACK follows
    task automatic reset_mid_bus();
        for (int c = 0; c <= 6; c++) begin
            @(posedge clk); #1;
            rv32 = (c <= 2); rv64 = (c <= 2);
            req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
            req_addr = 32'h40; req_wdata = 64'd0;
            reset = (c == 2);
            ACK = (c == 4); ERR = 1'b0;
            Data_I = {$urandom, $urandom};
            for (int d = 0; d < 2; d++) begin
                exp_busy[d] = (c == 1 || c == 2);
                exp_stb[d]  = (c == 1 || c == 2);
                exp_rv[d]   = 1'b0;
                exp_code[d] = 2'd0;
                exp_we[d]   = 1'b0;
                exp_addr[d] = 32'h40;
                exp_sel[d]  = m_sel(d ? 64 : 32, 2'd2, 32'h40);
                exp_do[d]   = 64'd0;
            end
        end
        txn_no++;
        $display("txn %0d reset during BUS, late ACK", txn_no);
    endtask

    initial begin
        reset = 1'b1; rv32 = 1'b0; rv64 = 1'b0;
        req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 64'd0; Data_I = 64'd0;
        ACK = 1'b0; ERR = 1'b0;
        set_idle_exp();
        for (int d = 0; d < 2; d++) begin
            exp_we[d] = 1'b0; exp_addr[d] = 32'd0; exp_sel[d] = 8'd0;
            exp_do[d] = 64'd0; exp_rdata[d] = 64'd0;
        end
        clear_last();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", 64'(a_busy[d]), 64'd0);
            chk("rst_rsp_valid", 64'(a_rv[d]), 64'd0);
            chk("rst_rsp_err", 64'(a_err[d]), 64'd0);
            chk("rst_stb", 64'(a_stb[d]), 64'd0);
            chk("rst_we", 64'(a_we[d]), 64'd0);
            chk("rst_addr", 64'(a_addr[d]), 64'd0);
            chk("rst_sel", 64'(a_sel[d]), 64'd0);
            chk("rst_data_o", a_do[d], 64'd0);
            chk("rst_rdata", a_rdata[d], 64'd0);
            chk("rst_code", 64'(a_code[d]), 64'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        chk_en = 1'b1;

        // lw 0x10, zero-wait slave
        clear_last();
        txn(1'b0, 2'd2, 1'b0, 32'h10, 64'd0, 64'h0000_0000_DEAD_BEEF, 0, 1'b0, 1'b0);
        settle();
        chk("pin_lw_rdata32", last_rdata[0], 64'hDEAD_BEEF);
        chk("pin_lw_rdata64", last_rdata[1], 64'hDEAD_BEEF);
        chk("pin_lw_code32", 64'(last_code[0]), 64'd0);

        // sb 0x13, three wait states
        clear_last();
        txn(1'b1, 2'd0, 1'b0, 32'h13, 64'hA5, {$urandom, $urandom}, 3, 1'b0, 1'b0);
        settle();
        chk("pin_sb_addr32", 64'(last_addr[0]), 64'h10);
        chk("pin_sb_sel32", 64'(last_sel[0]), 64'h08);
        chk("pin_sb_data32", last_do[0], 64'hA500_0000);
        chk("pin_sb_sel64", 64'(last_sel[1]), 64'h08);

        // lh 0x22 signed then unsigned
        clear_last();
        txn(1'b0, 2'd1, 1'b1, 32'h22, 64'd0, 64'h0000_0000_8001_1234, 1, 1'b0, 1'b0);
        settle();
        chk("pin_lh_s32", last_rdata[0], 64'hFFFF_8001);
        chk("pin_lh_s64", last_rdata[1], 64'hFFFF_FFFF_FFFF_8001);
        clear_last();
        txn(1'b0, 2'd1, 1'b0, 32'h22, 64'd0, 64'h0000_0000_8001_1234, 1, 1'b0, 1'b0);
        settle();
        chk("pin_lh_u32", last_rdata[0], 64'h8001);
        chk("pin_lh_u64", last_rdata[1], 64'h8001);

        // lw 0x6 misaligned
        clear_last();
        txn(1'b0, 2'd2, 1'b0, 32'h6, 64'd0, 64'd0, 0, 1'b0, 1'b0);
        settle();
        chk("pin_mis_code32", 64'(last_code[0]), 64'd1);
        chk("pin_mis_code64", 64'(last_code[1]), 64'd1);

        // ld 0x8: illegal on 32-bit, full lane set on 64-bit
        clear_last();
        txn(1'b0, 2'd3, 1'b0, 32'h8, 64'd0, 64'h0123_4567_89AB_CDEF, 2, 1'b0, 1'b0);
        settle();
        chk("pin_ld_code32", 64'(last_code[0]), 64'd1);
        chk("pin_ld_sel64", 64'(last_sel[1]), 64'hFF);
        chk("pin_ld_rdata64", last_rdata[1], 64'h0123_4567_89AB_CDEF);

        // silent slave: watchdog, with the ACK arriving long after
        clear_last();
        txn(1'b0, 2'd2, 1'b0, 32'h20, 64'd0, 64'd0, 9, 1'b0, 1'b0);
        settle();
        chk("pin_tmo_code32", 64'(last_code[0]), 64'd3);
        chk("pin_tmo_code64", 64'(last_code[1]), 64'd3);

        // ERR and ACK together
        clear_last();
        txn(1'b1, 2'd2, 1'b0, 32'h24, 64'h1234_5678, 64'd0, 2, 1'b1, 1'b1);
        settle();
        chk("pin_err_code32", 64'(last_code[0]), 64'd2);
        chk("pin_err_code64", 64'(last_code[1]), 64'd2);

        reset_mid_bus();
        idle_cycles(2);

        for (int n = 0; n < 250; n++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 6),
                ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end
        idle_cycles(3);
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
